// File: rtl/rob_squash_pkg.sv
// Shared types and default sizing for the reorder buffer.
// Packet layouts below are sized for the default configuration.
package rob_squash_pkg;

   localparam int SUPERSCALAR_WAYS = 3;
   localparam int ROB_SZ           = 32;
   localparam int PREG_W_DEF       = 6;
   localparam int AREG_W_DEF       = 5;
   localparam int ROB_IDX_W        = $clog2(ROB_SZ);

   typedef struct packed {
      logic                  valid;
      logic [PREG_W_DEF-1:0] t_idx;
      logic [PREG_W_DEF-1:0] told_idx;
      logic [AREG_W_DEF-1:0] ar_idx;
   } DISPATCH_ROB_PACKET;

   typedef struct packed {
      logic                 valid;
      logic [ROB_IDX_W-1:0] rob_idx;
   } COMPLETE_ROB_PACKET;

   typedef struct packed {
      logic                  valid;
      logic [PREG_W_DEF-1:0] t_idx;
      logic [PREG_W_DEF-1:0] told_idx;
      logic [AREG_W_DEF-1:0] ar_idx;
   } ROB_RETIRE_PACKET;

   typedef struct packed {
      logic                  valid;
      logic                  complete;
      logic [PREG_W_DEF-1:0] t_idx;
      logic [PREG_W_DEF-1:0] told_idx;
      logic [AREG_W_DEF-1:0] ar_idx;
   } ROB_ENTRY;

endpackage

// File: rtl/rob_alloc.sv
// Per-way dispatch allocation: prefix counts of valid ways give
// each way its tail-relative slot and decide which ways stall.
module rob_alloc
   import rob_squash_pkg::*;
#(
   parameter int WAYS = SUPERSCALAR_WAYS,
   parameter int IW   = 5,
   parameter int CW   = 6
) (
   input  logic [WAYS-1:0]         valid_i,
   input  logic [CW-1:0]           free_i,
   input  logic [IW-1:0]           tail_i,
   output logic [WAYS-1:0]         stall_o,
   output logic [WAYS-1:0][IW-1:0] idx_o,
   output logic [CW-1:0]           acc_o
);

   logic [CW-1:0] run;

   always_comb begin
      run     = '0;
      acc_o   = '0;
      stall_o = '0;
      idx_o   = '0;
      for (int i = 0; i < WAYS; i++) begin
         idx_o[i] = tail_i + IW'(run);
         if (valid_i[i]) begin
            run        = run + CW'(1);
            stall_o[i] = (run > free_i);
            if (!stall_o[i])
               acc_o = acc_o + CW'(1);
         end
      end
   end

endmodule

// File: rtl/rob_squash.sv
// Circular reorder buffer with in-order multi-way dispatch and
// retirement, branch squash and full flush.
module rob_squash
   import rob_squash_pkg::*;
#(
   parameter int WAYS   = SUPERSCALAR_WAYS,
   parameter int DEPTH  = ROB_SZ,
   parameter int PREG_W = PREG_W_DEF,
   parameter int AREG_W = AREG_W_DEF
) (
   input  logic                                 clock,
   input  logic                                 reset,
   input  logic [WAYS-1:0]                      disp_valid,
   input  logic [WAYS-1:0][PREG_W-1:0]          disp_t_idx,
   input  logic [WAYS-1:0][PREG_W-1:0]          disp_told_idx,
   input  logic [WAYS-1:0][AREG_W-1:0]          disp_ar_idx,
   output logic [WAYS-1:0]                      disp_stall,
   output logic [WAYS-1:0][$clog2(DEPTH)-1:0]   disp_rob_idx,
   input  logic [WAYS-1:0]                      cmpl_valid,
   input  logic [WAYS-1:0][$clog2(DEPTH)-1:0]   cmpl_rob_idx,
   input  logic                                 squash,
   input  logic [$clog2(DEPTH)-1:0]             squash_rob_idx,
   input  logic                                 flush,
   output logic [WAYS-1:0]                      ret_valid,
   output logic [WAYS-1:0][PREG_W-1:0]          ret_t_idx,
   output logic [WAYS-1:0][PREG_W-1:0]          ret_told_idx,
   output logic [WAYS-1:0][AREG_W-1:0]          ret_ar_idx,
   output logic [$clog2(DEPTH+1)-1:0]           free_cnt
);

   localparam int IW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);

   logic [IW-1:0]     head_q, head_d, tail_q, tail_d;
   logic [CW-1:0]     count_q, count_d;
   logic [DEPTH-1:0]  vld_q, vld_d, cmp_q, cmp_d;
   logic [PREG_W-1:0] t_q    [DEPTH];
   logic [PREG_W-1:0] told_q [DEPTH];
   logic [AREG_W-1:0] ar_q   [DEPTH];

   logic [CW-1:0] acc, nret;
   logic          sq_ok, chain;
   logic [IW-1:0] sq_keep, sq_young, ridx, off;

   assign free_cnt = CW'(DEPTH) - count_q;

   rob_alloc #(.WAYS(WAYS), .IW(IW), .CW(CW)) u_alloc (
      .valid_i (disp_valid),
      .free_i  (free_cnt),
      .tail_i  (tail_q),
      .stall_o (disp_stall),
      .idx_o   (disp_rob_idx),
      .acc_o   (acc)
   );

   assign sq_ok    = squash && vld_q[squash_rob_idx]
                     && (squash_rob_idx != tail_q);
   assign sq_keep  = squash_rob_idx - head_q;
   assign sq_young = tail_q - squash_rob_idx - IW'(1);

   // A squash also caps retirement at the branch so the count stays exact.
   always_comb begin
      ret_valid    = '0;
      ret_t_idx    = '0;
      ret_told_idx = '0;
      ret_ar_idx   = '0;
      nret         = '0;
      chain        = 1'b1;
      ridx         = '0;
      for (int i = 0; i < WAYS; i++) begin
         ridx  = head_q + IW'(i);
         chain = chain && vld_q[ridx] && cmp_q[ridx] && !flush
                 && !(sq_ok && (IW'(i) > sq_keep));
         ret_valid[i] = chain;
         nret         = nret + CW'(chain);
         if (vld_q[ridx]) begin
            ret_t_idx[i]    = t_q[ridx];
            ret_told_idx[i] = told_q[ridx];
            ret_ar_idx[i]   = ar_q[ridx];
         end
      end
   end

   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      vld_d   = vld_q;
      cmp_d   = cmp_q;
      off     = '0;
      if (flush) begin
         vld_d   = '0;
         cmp_d   = '0;
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
      end else begin
         for (int i = 0; i < WAYS; i++)
            if (cmpl_valid[i] && vld_q[cmpl_rob_idx[i]])
               cmp_d[cmpl_rob_idx[i]] = 1'b1;
         for (int i = 0; i < WAYS; i++)
            if (ret_valid[i]) begin
               vld_d[head_q + IW'(i)] = 1'b0;
               cmp_d[head_q + IW'(i)] = 1'b0;
            end
         if (sq_ok) begin
            for (int j = 0; j < DEPTH; j++) begin
               off = IW'(j) - squash_rob_idx - IW'(1);
               if (off < sq_young) begin
                  vld_d[j] = 1'b0;
                  cmp_d[j] = 1'b0;
               end
            end
            tail_d  = squash_rob_idx + IW'(1);
            count_d = count_q - nret - CW'(sq_young);
         end else begin
            for (int i = 0; i < WAYS; i++)
               if (disp_valid[i] && !disp_stall[i]) begin
                  vld_d[disp_rob_idx[i]] = 1'b1;
                  cmp_d[disp_rob_idx[i]] = 1'b0;
               end
            tail_d  = tail_q + IW'(acc);
            count_d = count_q + acc - nret;
         end
         head_d = head_q + IW'(nret);
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         vld_q   <= '0;
         cmp_q   <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
         vld_q   <= vld_d;
         cmp_q   <= cmp_d;
      end
   end

   always_ff @(posedge clock) begin
      for (int i = 0; i < WAYS; i++)
         if (!flush && !sq_ok && disp_valid[i] && !disp_stall[i]) begin
            t_q[disp_rob_idx[i]]    <= disp_t_idx[i];
            told_q[disp_rob_idx[i]] <= disp_told_idx[i];
            ar_q[disp_rob_idx[i]]   <= disp_ar_idx[i];
         end
   end

endmodule

// File: tb/tb_rob_squash.sv
// Directed and randomized checks of rob_squash against a
// queue-based reference model of the reorder buffer.
module tb_rob_squash;
   import rob_squash_pkg::*;

   localparam int W = 3;
   localparam int D = 32;

   logic clock = 1'b0;
   logic reset = 1'b0;
   always #5 clock = ~clock;

   logic [W-1:0]        disp_valid;
   logic [W-1:0][5:0]   disp_t_idx, disp_told_idx;
   logic [W-1:0][4:0]   disp_ar_idx;
   logic [W-1:0]        disp_stall;
   logic [W-1:0][4:0]   disp_rob_idx;
   logic [W-1:0]        cmpl_valid;
   logic [W-1:0][4:0]   cmpl_rob_idx;
   logic                squash;
   logic [4:0]          squash_rob_idx;
   logic                flush;
   logic [W-1:0]        ret_valid;
   logic [W-1:0][5:0]   ret_t_idx, ret_told_idx;
   logic [W-1:0][4:0]   ret_ar_idx;
   logic [5:0]          free_cnt;

   rob_squash dut (
      .clock(clock), .reset(reset),
      .disp_valid(disp_valid), .disp_t_idx(disp_t_idx),
      .disp_told_idx(disp_told_idx), .disp_ar_idx(disp_ar_idx),
      .disp_stall(disp_stall), .disp_rob_idx(disp_rob_idx),
      .cmpl_valid(cmpl_valid), .cmpl_rob_idx(cmpl_rob_idx),
      .squash(squash), .squash_rob_idx(squash_rob_idx),
      .flush(flush), .ret_valid(ret_valid),
      .ret_t_idx(ret_t_idx), .ret_told_idx(ret_told_idx),
      .ret_ar_idx(ret_ar_idx), .free_cnt(free_cnt)
   );

   int n_assert = 0;
   int n_fail   = 0;

   // Model: oldest-first queue of live entries; hd is the head slot.
   ROB_ENTRY q[$];
   int       hd = 0;
   logic [W-1:0] es, er;
   int       ei [W];
   int       sqk;
   bit       sqok;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_assert++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic clr();
      disp_valid     = '0;
      disp_t_idx     = '0;
      disp_told_idx  = '0;
      disp_ar_idx    = '0;
      cmpl_valid     = '0;
      cmpl_rob_idx   = '0;
      squash         = 1'b0;
      squash_rob_idx = '0;
      flush          = 1'b0;
   endtask

   task automatic predict();
      int sz, fr, run;
      bit ch;
      sz  = q.size();
      fr  = D - sz;
      run = 0;
      for (int i = 0; i < W; i++) begin
         es[i] = 1'b0;
         ei[i] = 0;
         if (disp_valid[i]) begin
            run++;
            es[i] = (run > fr);
            ei[i] = (hd + sz + run - 1) % D;
         end
      end
      sqk  = ((int'(squash_rob_idx) - hd) % D + D) % D;
      sqok = squash && (sqk < sz) && (int'(squash_rob_idx) != (hd + sz) % D);
      ch = 1'b1;
      for (int i = 0; i < W; i++) begin
         ch = ch && (i < sz) && !flush && !(sqok && i > sqk);
         if (ch) ch = q[i].complete;
         er[i] = ch;
      end
   endtask

   task automatic check_outputs();
      predict();
      chk("free_cnt", free_cnt, D - q.size());
      chk("disp_stall", disp_stall, es);
      for (int i = 0; i < W; i++)
         if (disp_valid[i] && !es[i])
            chk("disp_rob_idx", disp_rob_idx[i], ei[i]);
      chk("ret_valid", ret_valid, er);
      for (int i = 0; i < W; i++) begin
         if (i < q.size()) begin
            chk("ret_t_idx", ret_t_idx[i], q[i].t_idx);
            chk("ret_told_idx", ret_told_idx[i], q[i].told_idx);
            chk("ret_ar_idx", ret_ar_idx[i], q[i].ar_idx);
         end else begin
            chk("ret_t_zero", ret_t_idx[i], 0);
            chk("ret_ar_zero", ret_ar_idx[i], 0);
         end
      end
   endtask

   task automatic update_model();
      int sz, kc, n;
      ROB_ENTRY e;
      if (flush) begin
         q.delete();
         hd = 0;
      end else begin
         sz = q.size();
         for (int i = 0; i < W; i++)
            if (cmpl_valid[i]) begin
               kc = ((int'(cmpl_rob_idx[i]) - hd) % D + D) % D;
               if (kc < sz) begin
                  e = q[kc];
                  e.complete = 1'b1;
                  q[kc] = e;
               end
            end
         if (sqok)
            while (q.size() > sqk + 1) void'(q.pop_back());
         n = 0;
         for (int i = 0; i < W; i++)
            if (er[i]) begin
               void'(q.pop_front());
               n++;
            end
         hd = (hd + n) % D;
         if (!sqok)
            for (int i = 0; i < W; i++)
               if (disp_valid[i] && !es[i])
                  q.push_back('{1'b1, 1'b0, disp_t_idx[i],
                                disp_told_idx[i], disp_ar_idx[i]});
      end
   endtask

   task automatic tick();
      @(negedge clock);
      check_outputs();
      @(posedge clock);
      update_model();
      #1;
   endtask

   task automatic rnd_fields();
      for (int i = 0; i < W; i++) begin
         disp_t_idx[i]    = 6'($urandom);
         disp_told_idx[i] = 6'($urandom);
         disp_ar_idx[i]   = 5'($urandom);
      end
   endtask

   initial begin
      clr();
      #12;
      chk("rst_free", free_cnt, 32);
      chk("rst_ret", ret_valid, 0);
      chk("rst_stall", disp_stall, 0);
      chk("rst_t", ret_t_idx, 0);
      chk("rst_ar", ret_ar_idx, 0);
      reset = 1'b1;
      @(posedge clock);
      #1;

      for (int n = 0; n < 32; n++) begin
         rnd_fields();
         disp_valid    = 3'b001;
         disp_t_idx[0] = 6'(2 * n);
         tick();
      end
      chk("full_free", free_cnt, 0);
      disp_valid = 3'b001;
      #1 chk("stall_33rd", disp_stall[0], 1);
      tick();

      disp_valid = 3'b111;
      #1 chk("full_stall", disp_stall, 3'b111);
      tick();
      clr();
      cmpl_valid = 3'b001;
      tick();
      clr();
      #1 chk("head_ret", ret_valid, 3'b001);
      chk("head_ret_t", ret_t_idx[0], 0);
      tick();
      chk("free_one", free_cnt, 1);

      cmpl_valid      = 3'b001;
      cmpl_rob_idx[0] = 5'd1;
      tick();
      clr();
      tick();
      rnd_fields();
      disp_valid = 3'b111;
      #1 chk("two_free_stall", disp_stall, 3'b100);
      chk("two_free_idx0", disp_rob_idx[0], 0);
      chk("two_free_idx1", disp_rob_idx[1], 1);
      tick();

      clr();
      flush = 1'b1;
      tick();
      clr();
      for (int n = 0; n < 4; n++) begin
         rnd_fields();
         disp_valid = (n == 3) ? 3'b001 : 3'b111;
         tick();
      end
      rnd_fields();
      squash         = 1'b1;
      squash_rob_idx = 5'd4;
      disp_valid     = 3'b111;
      tick();
      clr();
      chk("squash_free", free_cnt, D - 5);
      disp_valid = 3'b001;
      #1 chk("squash_idx", disp_rob_idx[0], 5);
      tick();

      clr();
      flush = 1'b1;
      tick();
      clr();
      for (int n = 0; n < 10; n++) begin
         rnd_fields();
         disp_valid = 3'b111;
         tick();
      end
      clr();
      for (int n = 0; n < 10; n++) begin
         cmpl_valid = 3'b111;
         for (int i = 0; i < W; i++) cmpl_rob_idx[i] = 5'(3 * n + i);
         tick();
      end
      clr();
      tick();
      tick();
      chk("drained_free", free_cnt, 32);
      rnd_fields();
      disp_valid = 3'b111;
      #1 chk("wrap_idx0", disp_rob_idx[0], 30);
      chk("wrap_idx1", disp_rob_idx[1], 31);
      chk("wrap_idx2", disp_rob_idx[2], 0);
      tick();
      clr();
      cmpl_valid   = 3'b111;
      cmpl_rob_idx = {5'd0, 5'd31, 5'd30};
      tick();
      clr();
      #1 chk("wrap_ret", ret_valid, 3'b111);
      tick();
      rnd_fields();
      disp_valid = 3'b001;
      #1 chk("tail_at_1", disp_rob_idx[0], 1);
      tick();
      clr();
      cmpl_valid      = 3'b001;
      cmpl_rob_idx[0] = 5'd1;
      tick();
      clr();
      #1 chk("head_at_1", ret_valid, 3'b001);
      tick();

      for (int n = 0; n < 4; n++) begin
         rnd_fields();
         disp_valid = (n == 3) ? 3'b001 : 3'b111;
         tick();
      end
      clr();
      cmpl_valid      = 3'b001;
      cmpl_rob_idx[0] = 5'(hd);
      tick();
      clr();
      #1 chk("pre_reset_ret", ret_valid, 3'b001);
      #2 reset = 1'b0;
      #1 chk("async_ret", ret_valid, 0);
      chk("async_free", free_cnt, 32);
      chk("async_stall", disp_stall, 0);
      q.delete();
      hd = 0;
      @(posedge clock);
      #3 reset = 1'b1;
      @(posedge clock);
      #1;
      rnd_fields();
      disp_valid = 3'b001;
      #1 chk("post_reset_idx", disp_rob_idx[0], 0);
      tick();

      for (int c = 0; c < 1500; c++) begin
         clr();
         rnd_fields();
         disp_valid = 3'($urandom_range(0, 7));
         for (int i = 0; i < W; i++) begin
            cmpl_valid[i]   = ((c / 200) % 2 == 0) ? ($urandom_range(0, 5) == 0)
                                                   : ($urandom_range(0, 1) == 0);
            cmpl_rob_idx[i] = 5'((hd + $urandom_range(0, q.size() + 1)) % D);
         end
         if ($urandom_range(0, 19) == 0) begin
            squash         = 1'b1;
            squash_rob_idx = 5'((hd + $urandom_range(0, q.size())) % D);
         end
         if ($urandom_range(0, 59) == 0) flush = 1'b1;
         tick();
      end

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_assert, n_fail);
      $finish;
   end

endmodule
